// File: rtl/pwm_pkg.sv
// Shared constants and saturating duty arithmetic for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned CONF_W      = 3;
    localparam int unsigned PRESC_W     = 7;
    localparam int unsigned SYNC_STAGES = 2;

    // a + b clipped to max_v; the carry bit keeps the sum from wrapping
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = 33'(a) + 33'(b);
        if (s > 33'(max_v)) begin
            return max_v;
        end
        return s[31:0];
    endfunction

    // a - b clipped at zero
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        if (a < b) begin
            return 32'd0;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronises an asynchronous level input and flags its rising edge for one clk.
module pwm_edge_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pwm_multi_channel_gen.sv
// Multi-channel PWM generator: shared prescaled period counter, per-channel
// shadow/active duty registers loaded at the period boundary.
// Optional build macro PWM_CENTER_ALIGN_EN selects an up/down (centre-aligned)
// counter with the shadow load at the valley; default is an edge-aligned sawtooth.
module pwm_multi_channel_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned STEP       = 16,
    parameter int unsigned RESET_DUTY = 128
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               ena,
    input  logic                                               inc,
    input  logic                                               dec,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
    input  logic [CONF_W-1:0]                                  conf,
    output logic [CHANNELS-1:0]                                pwm,
    output logic                                               period_start
);

    localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'(RESET_DUTY);

    logic [PRESC_W-1:0]  presc_q;
    logic [PRESC_W-1:0]  presc_mask;
    logic [WIDTH-1:0]    cnt_q;
    logic [WIDTH-1:0]    shadow_q   [CHANNELS];
    logic [WIDTH-1:0]    active_q   [CHANNELS];
    logic [WIDTH-1:0]    shadow_nxt [CHANNELS];
    logic [CHANNELS-1:0] pwm_nxt;
    logic                tick;
    logic                boundary;
    logic                inc_ev;
    logic                dec_ev;
    logic                edit_ok;

    pwm_edge_sync u_inc_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (inc),
        .rise_c   (inc_ev)
    );

    pwm_edge_sync u_dec_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (dec),
        .rise_c   (dec_ev)
    );

    // Tick when the low conf bits of the prescaler are all ones (conf=0: every clk)
    assign presc_mask = PRESC_W'((8'd1 << conf) - 8'd1);
    assign tick       = ena & ((presc_q & presc_mask) == presc_mask);

    // Prescaler runs only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (ena) begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic up_q;

    assign boundary = tick & (cnt_q == '0) & ~up_q;

    // Up/down counter, direction flips at each end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            up_q  <= 1'b1;
        end else if (tick) begin
            if (up_q) begin
                if (cnt_q == CNT_MAX) begin
                    up_q  <= 1'b0;
                    cnt_q <= cnt_q - WIDTH'(1);
                end else begin
                    cnt_q <= cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    up_q  <= 1'b1;
                    cnt_q <= cnt_q + WIDTH'(1);
                end else begin
                    cnt_q <= cnt_q - WIDTH'(1);
                end
            end
        end
    end
`else
    assign boundary = tick & (cnt_q == CNT_MAX);

    // Sawtooth counter wrapping naturally at 2^WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end
`endif

    // Simultaneous inc and dec cancel; nothing is edited while disabled
    assign edit_ok = ena & (inc_ev ^ dec_ev);

    // Per-channel shadow edit and compare
    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        logic hit;
        assign hit = edit_ok & (ch_sel == SEL_W'(i));
        assign shadow_nxt[i] = !hit   ? shadow_q[i] :
                               inc_ev ? WIDTH'(sat_add(32'(shadow_q[i]), STEP, 32'(CNT_MAX))) :
                                        WIDTH'(sat_sub(32'(shadow_q[i]), STEP));
        assign pwm_nxt[i] = ena & (cnt_q < active_q[i]);
    end

    // Duty registers and output flops; active takes the pre-edit shadow at the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= RST_DUTY;
                active_q[i] <= RST_DUTY;
            end
            pwm          <= '0;
            period_start <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_nxt[i];
                if (boundary) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            pwm          <= pwm_nxt;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// Self-checking bench for pwm_multi_channel_gen (default edge-aligned build).
module tb_pwm_multi_channel_gen;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       inc;
    logic       dec;
    logic [1:0] ch_sel;
    logic [2:0] conf;
    logic [3:0] pwm;
    logic       period_start;

    pwm_multi_channel_gen #(
        .WIDTH      (8),
        .CHANNELS   (4),
        .STEP       (16),
        .RESET_DUTY (128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .inc          (inc),
        .dec          (dec),
        .ch_sel       (ch_sel),
        .conf         (conf),
        .pwm          (pwm),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: enabled-clock count, tick count, duty registers, input history
    int   m_en;
    int   m_ticks;
    int   m_shadow [4];
    int   m_active [4];
    logic ih [3];
    logic dh [3];

    int   hi_cnt [4];
    int   ps_cnt;
    int   n_cyc;
    logic ps_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en    = 0;
        m_ticks = 0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 128;
            m_active[i] = 128;
        end
        for (int i = 0; i < 3; i++) begin
            ih[i] = 1'b0;
            dh[i] = 1'b0;
        end
    endtask

    task automatic zero_counts();
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        ps_cnt = 0;
        n_cyc  = 0;
    endtask

    // One clock: advance the model by the rules, then compare outputs after the edge
    task automatic cyc();
        logic [3:0] exp_pwm;
        logic       exp_ps;
        logic       tk;
        logic       iev;
        logic       dev;
        int         cnt;
        int         div;
        @(posedge clk);
        div = 1 << conf;
        cnt = m_ticks % 256;
        tk  = ena && ((m_en % div) == div - 1);
        for (int i = 0; i < 4; i++) exp_pwm[i] = ena && (cnt < m_active[i]);
        exp_ps = tk && (cnt == 255);
        iev = ih[1] && !ih[2];
        dev = dh[1] && !dh[2];
        if (exp_ps) begin
            for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        end
        if (ena && (iev != dev) && (ch_sel < 4)) begin
            if (iev) m_shadow[ch_sel] = (m_shadow[ch_sel] + 16 > 255) ? 255 : m_shadow[ch_sel] + 16;
            else     m_shadow[ch_sel] = (m_shadow[ch_sel] < 16) ? 0 : m_shadow[ch_sel] - 16;
        end
        ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = inc;
        dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = dec;
        if (tk)  m_ticks++;
        if (ena) m_en++;
        #1;
        check("pwm", 32'(pwm), 32'(exp_pwm));
        check("period_start", 32'(period_start), 32'(exp_ps));
        for (int i = 0; i < 4; i++) if (pwm[i]) hi_cnt[i]++;
        if (period_start) ps_cnt++;
        ps_last = period_start;
        n_cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic pulse(input logic do_inc, input logic do_dec);
        inc = do_inc;
        dec = do_dec;
        cyc();
        cyc();
        inc = 1'b0;
        dec = 1'b0;
        cyc();
        cyc();
    endtask

    // Run until a period_start is seen, failing the comparison if the budget expires
    task automatic wait_ps(input string tag, input int bound);
        int k;
        k = 0;
        ps_last = 1'b0;
        while (!ps_last && k < bound) begin
            cyc();
            k++;
        end
        check(tag, 32'(ps_last), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        inc    = 1'b0;
        dec    = 1'b0;
        ch_sel = 2'd0;
        conf   = 3'd0;
        model_reset();
        zero_counts();
        #1;
        check("reset_pwm", 32'(pwm), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena   = 1'b1;

        // Reset duty, conf=0: 128 high of every 256 clk, one period_start
        wait_ps("t1_first_boundary", 300);
        zero_counts();
        run(256);
        for (int i = 0; i < 4; i++) check($sformatf("t1_high_ch%0d", i), 32'(hi_cnt[i]), 32'd128);
        check("t1_ps_count", 32'(ps_cnt), 32'd1);

        // Three inc on channel 2 mid-period take effect at the next boundary
        run(100);
        ch_sel = 2'd2;
        repeat (3) pulse(1'b1, 1'b0);
        wait_ps("t2_boundary", 300);
        zero_counts();
        run(256);
        check("t2_high_ch2", 32'(hi_cnt[2]), 32'd176);
        check("t2_high_ch1", 32'(hi_cnt[1]), 32'd128);

        // Nine dec on channel 0 saturate at 0; sixteen inc saturate at 255
        ch_sel = 2'd0;
        repeat (9) pulse(1'b0, 1'b1);
        wait_ps("t3_boundary_lo", 300);
        zero_counts();
        run(256);
        check("t3_high_ch0_zero", 32'(hi_cnt[0]), 32'd0);
        repeat (16) pulse(1'b1, 1'b0);
        wait_ps("t3_boundary_hi", 300);
        zero_counts();
        run(256);
        check("t3_high_ch0_max", 32'(hi_cnt[0]), 32'd255);

        // conf=3: tick every 8 clk; inc+dec together leaves channel 1 unchanged
        conf   = 3'd3;
        ch_sel = 2'd1;
        pulse(1'b1, 1'b1);
        wait_ps("t4_boundary", 2600);
        zero_counts();
        run(2048);
        check("t4_high_ch1", 32'(hi_cnt[1]), 32'd1024);
        check("t4_high_ch2", 32'(hi_cnt[2]), 32'd1408);
        check("t4_ps_count", 32'(ps_cnt), 32'd1);

        // ena low for 50 clk mid-period: outputs low, counter frozen, period stretched
        conf = 3'd0;
        wait_ps("t5_boundary", 2600);
        zero_counts();
        run(100);
        ena = 1'b0;
        cyc();
        check("t5_ena_low_pwm", 32'(pwm), 32'd0);
        run(49);
        ena = 1'b1;
        wait_ps("t5_resume_boundary", 400);
        check("t5_stretched_period", 32'(n_cyc), 32'd306);
        check("t5_high_ch2", 32'(hi_cnt[2]), 32'd176);

        // Asynchronous reset mid-period
        run(77);
        rst_n = 1'b0;
        #1;
        check("t5_async_rst_pwm", 32'(pwm), 32'd0);
        check("t5_async_rst_ps", 32'(period_start), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ps("t5_post_rst_boundary", 300);
        zero_counts();
        run(256);
        for (int i = 0; i < 4; i++) check($sformatf("t5_post_rst_ch%0d", i), 32'(hi_cnt[i]), 32'd128);

        // Randomised edits, prescale changes and enable gaps against the model
        for (int it = 0; it < 40; it++) begin
            ch_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) conf = 3'($urandom_range(0, 2));
            ena = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 2))
                0:       pulse(1'b1, 1'b0);
                1:       pulse(1'b0, 1'b1);
                default: pulse(1'b1, 1'b1);
            endcase
            ena = 1'b1;
            run($urandom_range(1, 60));
        end
        conf = 3'd0;
        run(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
